// File: rtl/rc4_pkg.sv
// Shared definitions for the RC4 stream cipher: FSM states and S-box geometry.
package rc4_pkg;
   localparam int SBOX_DEPTH = 256;
   localparam int IDX_W      = 8;

   typedef enum logic [2:0] {
      IDLE,
      INIT,
      KSA,
      DROP,
      PRGA
   } rc4_state_t;
endpackage

// File: rtl/rc4_stream_cipher_if.sv
// Byte-stream handshake bundle: an input stream (used in XOR mode) and an output stream.
interface rc4_stream_cipher_if;
   import rc4_pkg::*;

   logic             in_valid;
   logic             in_ready;
   logic [IDX_W-1:0] in_data;
   logic             out_valid;
   logic             out_ready;
   logic [IDX_W-1:0] out_data;

   modport master (
      output in_valid, in_data, out_ready,
      input  in_ready, out_valid, out_data
   );

   modport slave (
      input  in_valid, in_data, out_ready,
      output in_ready, out_valid, out_data
   );
endinterface

// File: rtl/rc4_sbox.sv
// 256x8 RC4 state register file: three combinational reads, two writes per cycle.
// Write port B lands after port A, so B wins when both target the same entry.
module rc4_sbox
   import rc4_pkg::*;
(
   input  logic             clk,
   input  logic [IDX_W-1:0] rd_a_addr,
   input  logic [IDX_W-1:0] rd_b_addr,
   input  logic [IDX_W-1:0] rd_t_addr,
   output logic [IDX_W-1:0] rd_a_data,
   output logic [IDX_W-1:0] rd_b_data,
   output logic [IDX_W-1:0] rd_t_data,
   input  logic             wr_a_en,
   input  logic [IDX_W-1:0] wr_a_addr,
   input  logic [IDX_W-1:0] wr_a_data,
   input  logic             wr_b_en,
   input  logic [IDX_W-1:0] wr_b_addr,
   input  logic [IDX_W-1:0] wr_b_data
);
   logic [IDX_W-1:0] mem [SBOX_DEPTH];

   assign rd_a_data = mem[rd_a_addr];
   assign rd_b_data = mem[rd_b_addr];
   assign rd_t_data = mem[rd_t_addr];

   always_ff @(posedge clk) begin
      if (wr_a_en) mem[wr_a_addr] <= wr_a_data;
      if (wr_b_en) mem[wr_b_addr] <= wr_b_data;
   end
endmodule

// File: rtl/rc4_stream_cipher.sv
// RC4 engine: INIT+KSA take 512 cycles (+DROP_N discards), then one byte/cycle with 1-cycle registered output.
// Output is held while out_valid && !out_ready; input is accepted only when the output slot is free.
module rc4_stream_cipher
   import rc4_pkg::*;
#(
   parameter int MAX_KEY_BYTES = 16,
   parameter int DROP_N        = 0
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       start,
   input  logic [MAX_KEY_BYTES*8-1:0] key,
   input  logic [8:0]                 key_length,
   input  logic                       xor_mode,
   output logic                       busy,
   output logic                       keyed,
   output logic                       err,
   rc4_stream_cipher_if.slave         strm
);
   localparam int KIDX_W = (MAX_KEY_BYTES > 1) ? $clog2(MAX_KEY_BYTES) : 1;
   localparam logic [11:0] DROP_LAST = 12'(DROP_N - 1);

   rc4_state_t state, state_nx;
   logic [IDX_W-1:0]  i_q, i_nx, j_q, j_nx, i_inc, i_rd, j_new;
   logic [IDX_W-1:0]  s_i, s_j, s_t, t_idx, ks, key_byte;
   logic [KIDX_W-1:0] kidx_q, kidx_nx;
   logic [11:0]       drop_q, drop_nx;
   logic [7:0]        key_q [MAX_KEY_BYTES];
   logic [8:0]        len_q;
   logic              xor_q;
   logic              len_ok, start_ok, out_free, fire, swap_en, init_en;

   assign len_ok   = (key_length != 9'd0) && (key_length <= 9'(MAX_KEY_BYTES));
   assign start_ok = start && len_ok && ((state == IDLE) || (state == PRGA));
   assign keyed    = (state == PRGA);
   assign busy     = (state inside {INIT, KSA, DROP});
   assign out_free = !strm.out_valid || strm.out_ready;
   assign strm.in_ready = keyed && out_free && xor_q;
   assign fire     = keyed && out_free && (strm.in_valid || !xor_q) && !start_ok;

   // KSA uses the current i; DROP/PRGA pre-increment i before reading.
   assign key_byte = key_q[kidx_q];
   assign i_inc    = i_q + 8'd1;
   assign i_rd     = (state == KSA) ? i_q : i_inc;
   assign j_new    = j_q + s_i + ((state == KSA) ? key_byte : 8'd0);
   assign t_idx    = s_i + s_j;
   assign ks       = (t_idx == i_rd)  ? s_j :
                     (t_idx == j_new) ? s_i : s_t;

   rc4_sbox u_sbox (
      .clk       (clk),
      .rd_a_addr (i_rd),
      .rd_b_addr (j_new),
      .rd_t_addr (t_idx),
      .rd_a_data (s_i),
      .rd_b_data (s_j),
      .rd_t_data (s_t),
      .wr_a_en   (init_en || swap_en),
      .wr_a_addr (init_en ? i_q : i_rd),
      .wr_a_data (init_en ? i_q : s_j),
      .wr_b_en   (swap_en),
      .wr_b_addr (j_new),
      .wr_b_data (s_i)
   );

   always_comb begin
      state_nx = state;
      i_nx     = i_q;
      j_nx     = j_q;
      kidx_nx  = kidx_q;
      drop_nx  = drop_q;
      swap_en  = 1'b0;
      init_en  = 1'b0;
      unique case (state)
         IDLE: begin
            if (start_ok) begin
               state_nx = INIT;
               i_nx     = '0;
            end
         end
         INIT: begin
            init_en = 1'b1;
            i_nx    = i_inc;
            if (i_q == 8'hFF) begin
               state_nx = KSA;
               j_nx     = '0;
               kidx_nx  = '0;
            end
         end
         KSA: begin
            swap_en = 1'b1;
            i_nx    = i_inc;
            j_nx    = j_new;
            kidx_nx = (9'(kidx_q) == len_q - 9'd1) ? '0 : kidx_q + 1'b1;
            if (i_q == 8'hFF) begin
               j_nx     = '0;
               drop_nx  = '0;
               state_nx = (DROP_N > 0) ? DROP : PRGA;
            end
         end
         DROP: begin
            swap_en = 1'b1;
            i_nx    = i_inc;
            j_nx    = j_new;
            drop_nx = drop_q + 12'd1;
            if (drop_q == DROP_LAST) state_nx = PRGA;
         end
         PRGA: begin
            if (start_ok) begin
               state_nx = INIT;
               i_nx     = '0;
            end else if (fire) begin
               swap_en = 1'b1;
               i_nx    = i_inc;
               j_nx    = j_new;
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= IDLE;
         i_q    <= '0;
         j_q    <= '0;
         kidx_q <= '0;
         drop_q <= '0;
      end else begin
         state  <= state_nx;
         i_q    <= i_nx;
         j_q    <= j_nx;
         kidx_q <= kidx_nx;
         drop_q <= drop_nx;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         len_q <= '0;
         xor_q <= 1'b0;
         err   <= 1'b0;
         for (int k = 0; k < MAX_KEY_BYTES; k++) key_q[k] <= '0;
      end else begin
         err <= start && !len_ok && ((state == IDLE) || (state == PRGA));
         if (start_ok) begin
            len_q <= key_length;
            xor_q <= xor_mode;
            for (int k = 0; k < MAX_KEY_BYTES; k++) key_q[k] <= key[8*k +: 8];
         end
      end
   end

   // A re-key discards any byte still waiting in the output register.
   always_ff @(posedge clk) begin
      if (rst) begin
         strm.out_valid <= 1'b0;
         strm.out_data  <= '0;
      end else if (start_ok) begin
         strm.out_valid <= 1'b0;
      end else if (fire) begin
         strm.out_valid <= 1'b1;
         strm.out_data  <= xor_q ? (strm.in_data ^ ks) : ks;
      end else if (strm.out_ready) begin
         strm.out_valid <= 1'b0;
      end
   end
endmodule

// File: tb/tb_rc4_stream_cipher.sv
// Directed bench for rc4_stream_cipher against published RC4 vectors; dut1 runs with DROP_N=4.
module tb_rc4_stream_cipher;
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic         rst, start, xor_mode;
   logic [127:0] key;
   logic [8:0]   key_length;
   logic         busy0, keyed0, err0, busy1, keyed1, err1;

   rc4_stream_cipher_if s0 ();
   rc4_stream_cipher_if s1 ();

   rc4_stream_cipher #(.MAX_KEY_BYTES(16), .DROP_N(0)) dut0 (
      .clk(clk), .rst(rst), .start(start), .key(key), .key_length(key_length),
      .xor_mode(xor_mode), .busy(busy0), .keyed(keyed0), .err(err0), .strm(s0));

   rc4_stream_cipher #(.MAX_KEY_BYTES(16), .DROP_N(4)) dut1 (
      .clk(clk), .rst(rst), .start(start), .key(key), .key_length(key_length),
      .xor_mode(xor_mode), .busy(busy1), .keyed(keyed1), .err(err1), .strm(s1));

   localparam logic [127:0] KEY_KEY  = 128'h79654B;
   localparam logic [127:0] KEY_5    = 128'h0504030201;
   localparam logic [127:0] KEY_WIKI = 128'h696B6957;

   int checks   = 0;
   int failures = 0;
   logic [7:0] got [16];
   logic [7:0] pt  [16];
   int ngot;
   int npt;

   // Called at a negedge; returns at the negedge right after the sampling edge.
   task automatic pulse_start(input logic [127:0] k, input logic [8:0] len, input logic m);
      key = k; key_length = len; xor_mode = m; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_keyed(input bit which, output int cyc);
      cyc = 0;
      while (!(which ? keyed1 : keyed0) && cyc < 1000) begin
         @(negedge clk);
         cyc++;
      end
   endtask

   task automatic collect0(input int n, input bit stall, input bit use_in);
      int budget = 0;
      int pi = 0;
      bit held_vld = 1'b0;
      logic [7:0] held = '0;
      ngot = 0;
      while (ngot < n && budget < 500) begin
         s0.out_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
         s0.in_valid  = use_in && (pi < npt);
         s0.in_data   = (pi < 16) ? pt[pi] : 8'h00;
         #1;
         if (held_vld) begin
            checks++;
            if (s0.out_valid !== 1'b1 || s0.out_data !== held) begin
               failures++;
               $display("FAIL stall_hold: got vld=%b data=%02h expected vld=1 data=%02h",
                        s0.out_valid, s0.out_data, held);
            end
         end
         if (s0.out_valid && s0.out_ready) begin
            got[ngot] = s0.out_data;
            ngot++;
         end
         if (s0.in_valid && s0.in_ready) pi++;
         held_vld = s0.out_valid && !s0.out_ready;
         held     = s0.out_data;
         @(negedge clk);
         budget++;
      end
      s0.in_valid = 1'b0;
      checks++;
      if (ngot != n) begin
         failures++;
         $display("FAIL collect_count: got %0d bytes expected %0d", ngot, n);
      end
   endtask

   task automatic test_reset;
      rst = 1'b1;
      repeat (3) @(negedge clk);
      checks += 6;
      if (busy0 !== 1'b0)        begin failures++; $display("FAIL reset_busy: got %b expected 0", busy0); end
      if (keyed0 !== 1'b0)       begin failures++; $display("FAIL reset_keyed: got %b expected 0", keyed0); end
      if (err0 !== 1'b0)         begin failures++; $display("FAIL reset_err: got %b expected 0", err0); end
      if (s0.in_ready !== 1'b0)  begin failures++; $display("FAIL reset_in_ready: got %b expected 0", s0.in_ready); end
      if (s0.out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid: got %b expected 0", s0.out_valid); end
      if (s0.out_data !== 8'h00) begin failures++; $display("FAIL reset_out_data: got %02h expected 00", s0.out_data); end
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_keystream;
      logic [7:0] exp [5] = '{8'hEB, 8'h9F, 8'h77, 8'h81, 8'hB7};
      int cyc;
      s0.out_ready = 1'b0;
      pulse_start(KEY_KEY, 9'd3, 1'b0);
      checks += 2;
      if (busy0 !== 1'b1)  begin failures++; $display("FAIL busy_after_start: got %b expected 1", busy0); end
      if (keyed0 !== 1'b0) begin failures++; $display("FAIL keyed_after_start: got %b expected 0", keyed0); end
      wait_keyed(1'b0, cyc);
      checks += 2;
      if (cyc != 512)     begin failures++; $display("FAIL keyed_latency: got %0d expected 512", cyc); end
      if (busy0 !== 1'b0) begin failures++; $display("FAIL busy_at_keyed: got %b expected 0", busy0); end
      s0.out_ready = 1'b1;
      #1;
      checks++;
      if (s0.in_ready !== 1'b0) begin failures++; $display("FAIL ks_mode_in_ready: got %b expected 0", s0.in_ready); end
      collect0(5, 1'b0, 1'b0);
      for (int k = 0; k < 5; k++) begin
         checks++;
         if (got[k] !== exp[k]) begin
            failures++;
            $display("FAIL key_stream[%0d]: got %02h expected %02h", k, got[k], exp[k]);
         end
      end
   endtask

   task automatic test_key5_stalls;
      logic [7:0] exp [8] = '{8'hB2, 8'h39, 8'h63, 8'h05, 8'hF0, 8'h3D, 8'hC0, 8'h27};
      int cyc;
      for (int pass = 0; pass < 2; pass++) begin
         pulse_start(KEY_5, 9'd5, 1'b0);
         wait_keyed(1'b0, cyc);
         checks++;
         if (cyc != 512) begin failures++; $display("FAIL key5_latency: got %0d expected 512", cyc); end
         collect0(8, pass == 1, 1'b0);
         for (int k = 0; k < 8; k++) begin
            checks++;
            if (got[k] !== exp[k]) begin
               failures++;
               $display("FAIL key5_stream pass%0d[%0d]: got %02h expected %02h", pass, k, got[k], exp[k]);
            end
         end
      end
   endtask

   task automatic test_xor;
      logic [7:0] p   [9] = '{8'h50, 8'h6C, 8'h61, 8'h69, 8'h6E, 8'h74, 8'h65, 8'h78, 8'h74};
      logic [7:0] exp [9] = '{8'hBB, 8'hF3, 8'h16, 8'hE8, 8'hD9, 8'h40, 8'hAF, 8'h0A, 8'hD3};
      int cyc;
      for (int k = 0; k < 9; k++) pt[k] = p[k];
      npt = 9;
      pulse_start(KEY_KEY, 9'd3, 1'b1);
      wait_keyed(1'b0, cyc);
      collect0(9, 1'b0, 1'b1);
      for (int k = 0; k < 9; k++) begin
         checks++;
         if (got[k] !== exp[k]) begin
            failures++;
            $display("FAIL xor_cipher[%0d]: got %02h expected %02h", k, got[k], exp[k]);
         end
      end
      npt = 0;
   endtask

   task automatic test_drop;
      logic [7:0] exp [5] = '{8'hB7, 8'h34, 8'hCA, 8'h72, 8'hA7};
      int cyc;
      int budget = 0;
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      pulse_start(KEY_KEY, 9'd3, 1'b0);
      wait_keyed(1'b1, cyc);
      checks++;
      if (cyc != 516) begin failures++; $display("FAIL drop_latency: got %0d expected 516", cyc); end
      ngot = 0;
      while (ngot < 5 && budget < 50) begin
         if (s1.out_valid) begin
            got[ngot] = s1.out_data;
            ngot++;
         end
         @(negedge clk);
         budget++;
      end
      for (int k = 0; k < 5; k++) begin
         checks++;
         if (got[k] !== exp[k]) begin
            failures++;
            $display("FAIL drop4_stream[%0d]: got %02h expected %02h", k, got[k], exp[k]);
         end
      end
   endtask

   task automatic test_reject_ignore;
      logic [7:0] exp [5] = '{8'hEB, 8'h9F, 8'h77, 8'h81, 8'hB7};
      logic [8:0] bad [2] = '{9'd0, 9'd17};
      int cyc;
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      for (int b = 0; b < 2; b++) begin
         pulse_start(KEY_KEY, bad[b], 1'b0);
         checks += 2;
         if (err0 !== 1'b1)  begin failures++; $display("FAIL reject_err len=%0d: got %b expected 1", bad[b], err0); end
         if (busy0 !== 1'b0) begin failures++; $display("FAIL reject_busy len=%0d: got %b expected 0", bad[b], busy0); end
         @(negedge clk);
         checks += 2;
         if (err0 !== 1'b0)          begin failures++; $display("FAIL reject_err_pulse len=%0d: got %b expected 0", bad[b], err0); end
         if ((busy0 | keyed0) !== 1'b0) begin failures++; $display("FAIL reject_idle len=%0d: got busy=%b keyed=%b expected 0", bad[b], busy0, keyed0); end
      end
      pulse_start(KEY_KEY, 9'd3, 1'b0);
      repeat (300) @(negedge clk);
      pulse_start(KEY_WIKI, 9'd4, 1'b0);
      checks += 2;
      if (err0 !== 1'b0)  begin failures++; $display("FAIL ignore_err: got %b expected 0", err0); end
      if (busy0 !== 1'b1) begin failures++; $display("FAIL ignore_busy: got %b expected 1", busy0); end
      wait_keyed(1'b0, cyc);
      checks++;
      if (cyc != 211) begin failures++; $display("FAIL ignore_latency: got %0d expected 211", cyc); end
      collect0(5, 1'b0, 1'b0);
      for (int k = 0; k < 5; k++) begin
         checks++;
         if (got[k] !== exp[k]) begin
            failures++;
            $display("FAIL ignore_stream[%0d]: got %02h expected %02h", k, got[k], exp[k]);
         end
      end
   endtask

   task automatic test_rekey;
      logic [7:0] exp [5] = '{8'h60, 8'h44, 8'hDB, 8'h6D, 8'h41};
      int cyc;
      s0.out_ready = 1'b1;
      @(negedge clk);
      checks++;
      if (s0.out_valid !== 1'b1) begin failures++; $display("FAIL rekey_pending: got %b expected 1", s0.out_valid); end
      pulse_start(KEY_WIKI, 9'd4, 1'b0);
      checks += 2;
      if (s0.out_valid !== 1'b0) begin failures++; $display("FAIL rekey_drop_valid: got %b expected 0", s0.out_valid); end
      if (busy0 !== 1'b1)        begin failures++; $display("FAIL rekey_busy: got %b expected 1", busy0); end
      wait_keyed(1'b0, cyc);
      collect0(5, 1'b0, 1'b0);
      for (int k = 0; k < 5; k++) begin
         checks++;
         if (got[k] !== exp[k]) begin
            failures++;
            $display("FAIL rekey_stream[%0d]: got %02h expected %02h", k, got[k], exp[k]);
         end
      end
   endtask

   task automatic test_reset_mid_ksa;
      logic [7:0] exp [5] = '{8'hEB, 8'h9F, 8'h77, 8'h81, 8'hB7};
      int cyc;
      pulse_start(KEY_KEY, 9'd3, 1'b0);
      repeat (300) @(negedge clk);
      checks++;
      if (busy0 !== 1'b1) begin failures++; $display("FAIL mid_ksa_busy: got %b expected 1", busy0); end
      rst = 1'b1;
      @(negedge clk);
      checks += 6;
      if (busy0 !== 1'b0)        begin failures++; $display("FAIL midrst_busy: got %b expected 0", busy0); end
      if (keyed0 !== 1'b0)       begin failures++; $display("FAIL midrst_keyed: got %b expected 0", keyed0); end
      if (err0 !== 1'b0)         begin failures++; $display("FAIL midrst_err: got %b expected 0", err0); end
      if (s0.in_ready !== 1'b0)  begin failures++; $display("FAIL midrst_in_ready: got %b expected 0", s0.in_ready); end
      if (s0.out_valid !== 1'b0) begin failures++; $display("FAIL midrst_out_valid: got %b expected 0", s0.out_valid); end
      if (s0.out_data !== 8'h00) begin failures++; $display("FAIL midrst_out_data: got %02h expected 00", s0.out_data); end
      rst = 1'b0;
      pulse_start(KEY_KEY, 9'd3, 1'b0);
      wait_keyed(1'b0, cyc);
      checks++;
      if (cyc != 512) begin failures++; $display("FAIL midrst_latency: got %0d expected 512", cyc); end
      collect0(5, 1'b0, 1'b0);
      for (int k = 0; k < 5; k++) begin
         checks++;
         if (got[k] !== exp[k]) begin
            failures++;
            $display("FAIL midrst_stream[%0d]: got %02h expected %02h", k, got[k], exp[k]);
         end
      end
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; key = '0; key_length = '0; xor_mode = 1'b0;
      s0.in_valid = 1'b0; s0.in_data = '0; s0.out_ready = 1'b0;
      s1.in_valid = 1'b0; s1.in_data = '0; s1.out_ready = 1'b1;
      npt = 0; ngot = 0;
      test_reset;
      test_keystream;
      test_key5_stalls;
      test_xor;
      test_drop;
      test_reject_ignore;
      test_rekey;
      test_reset_mid_ksa;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
